// File: rtl/uart_bus_ctrl.sv
// UART bus-master sequencer: programs SCCR, polls SCSR, moves bytes between
// valid/ready streams and TDR/RDR, and buffers received bytes in a small FIFO.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | bus idle, choose next access (config > poll)
// CFG_WR | write SCCR with rie=1 and baudsel
// POLL   | read SCSR, pick RX drain, TX write or back to idle
// RD_RDR | read RDR, push into FIFO unless the byte had a frame error
// WR_TDR | write tx_data into TDR, accept the stream byte
module uart_bus_ctrl #(
   parameter int RX_DEPTH = 4,
   parameter int CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic [1:0]       baudsel,
   input  logic             cfg_start,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [CNT_W-1:0] rx_level,
   output logic             ovr_err,
   output logic             frm_err,
   input  logic             err_clr,
   input  logic             sciirq,
   output logic             scisel,
   output logic             rw,
   output logic [1:0]       addr,
   output logic [7:0]       dout,
   output logic             doe,
   input  logic [7:0]       din
);

   localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CFG_WR = 3'd1,
      POLL   = 3'd2,
      RD_RDR = 3'd3,
      WR_TDR = 3'd4
   } state_t;

   state_t state, state_nx;

   logic             run;
   logic             cfg_pend;
   logic             status_fe;
   logic             push, pop, fifo_full;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [7:0]       mem [RX_DEPTH];
   logic             unused_din;

   assign unused_din = ^din[5:2];

   assign fifo_full = (rx_level == CNT_W'(RX_DEPTH));
   assign rx_valid  = (rx_level != '0);
   assign pop       = rx_ready && rx_valid;
   assign push      = (state == RD_RDR) && !status_fe;
   assign rx_data   = mem[rd_ptr];

   // run holds off the first SCCR write for one cycle so reset outputs stay idle
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= CFG_WR;
         run   <= 1'b0;
      end else begin
         state <= state_nx;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      scisel   = 1'b0;
      rw       = 1'b0;
      addr     = 2'b00;
      dout     = 8'h00;
      doe      = 1'b0;
      tx_ready = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_pend)
               state_nx = CFG_WR;
            else if (sciirq || tx_valid)
               state_nx = POLL;
         end
         CFG_WR: begin
            if (run) begin
               scisel   = 1'b1;
               rw       = 1'b1;
               addr     = 2'b11;
               doe      = 1'b1;
               dout     = {1'b0, 1'b1, 4'b0000, baudsel};
               state_nx = IDLE;
            end
         end
         POLL: begin
            scisel = 1'b1;
            addr   = 2'b01;
            if (din[6] && !fifo_full)
               state_nx = RD_RDR;
            else if (din[7] && tx_valid)
               state_nx = WR_TDR;
            else
               state_nx = IDLE;
         end
         RD_RDR: begin
            scisel   = 1'b1;
            state_nx = IDLE;
         end
         WR_TDR: begin
            scisel   = 1'b1;
            rw       = 1'b1;
            doe      = 1'b1;
            dout     = tx_data;
            tx_ready = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cfg_pend  <= 1'b0;
         status_fe <= 1'b0;
         ovr_err   <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         if (cfg_start)
            cfg_pend <= 1'b1;
         else if (state == CFG_WR && run)
            cfg_pend <= 1'b0;

         if (state == POLL)
            status_fe <= din[0];

         // a new error seen in POLL outranks a simultaneous clear
         if (state == POLL && din[1])
            ovr_err <= 1'b1;
         else if (err_clr)
            ovr_err <= 1'b0;

         if (state == POLL && din[0])
            frm_err <= 1'b1;
         else if (err_clr)
            frm_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rx_level <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   rx_level <= rx_level + CNT_W'(1);
            2'b01:   rx_level <= rx_level - CNT_W'(1);
            default: rx_level <= rx_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= din;
   end

endmodule
